nubus_slave_ctl: RTL

Slave-side NuBus cycle controller for the test card, the responder for the card's master controller. It decodes start cycles addressed to this card's slot space and sequences local read/write strobes with programmable wait states. It returns a one-clock ACK carrying a NuBus status code. Attention cycles are recognised, including the lock-attention/null-attention pair, so that locked sequences from another master are honoured.

---
 rtl/nubus_slave_ctl.sv | 111 +++++++++++
 1 files changed

// File: rtl/nubus_slave_ctl.sv
// NuBus slave cycle controller: decodes slot-addressed START cycles, sequences local
// strobes with wait states, returns a one-clock ACK with status, and tracks lock-attention.
module nubus_slave_ctl #(
  parameter int WAIT_MIN = 1,
  parameter int TIMEOUT  = 200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       ACK,
  input  logic       ATTN,
  input  logic [3:0] ADHI,
  input  logic [3:0] SLOTID,
  input  logic [1:0] TM,
  input  logic       LRDY,
  input  logic       LBUSY,
  output logic       ADRLT,
  output logic       RDEN,
  output logic       WRSTB,
  output logic       SACK,
  output logic [1:0] STAT,
  output logic       MYCY,
  output logic       LOCKED
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, ACKC} state_t;

  localparam logic [7:0] WAIT_MIN_C = 8'(WAIT_MIN);
  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] count;
  logic       rd;
  logic       match;

  assign match = START & ~ATTN & (ADHI == SLOTID);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      count  <= '0;
      rd     <= 1'b0;
      ADRLT  <= 1'b0;
      RDEN   <= 1'b0;
      WRSTB  <= 1'b0;
      SACK   <= 1'b0;
      STAT   <= 2'b00;
      MYCY   <= 1'b0;
      LOCKED <= 1'b0;
    end else begin
      ADRLT <= 1'b0;
      WRSTB <= 1'b0;
      unique case (state)
        IDLE: begin
          if (match) begin
            state <= ADDR;
            ADRLT <= 1'b1;
            MYCY  <= 1'b1;
            rd    <= TM[1];
            RDEN  <= TM[1];
          end else if (START & ATTN & ~ACK) begin
            if (TM == 2'b01)      LOCKED <= 1'b1;
            else if (TM == 2'b00) LOCKED <= 1'b0;
          end
        end
        ADDR: begin
          count <= 8'd1;
          if (LBUSY) begin
            state <= ACKC;
            SACK  <= 1'b1;
            STAT  <= 2'b11;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // LRDY wins over timeout on the edge where both could apply
          if ((count >= WAIT_MIN_C) && LRDY) begin
            state <= ACKC;
            SACK  <= 1'b1;
            STAT  <= 2'b00;
            WRSTB <= ~rd;
          end else if (count == TIMEOUT_C) begin
            state <= ACKC;
            SACK  <= 1'b1;
            STAT  <= 2'b01;
          end else if (count < TIMEOUT_C) begin
            count <= count + 8'd1;
          end
        end
        ACKC: begin
          SACK <= 1'b0;
          STAT <= 2'b00;
          // a START on the edge SACK drops starts the next cycle back-to-back
          if (match) begin
            state <= ADDR;
            ADRLT <= 1'b1;
            MYCY  <= 1'b1;
            rd    <= TM[1];
            RDEN  <= TM[1];
          end else begin
            state <= IDLE;
            RDEN  <= 1'b0;
            MYCY  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
